// File: rtl/strip_frame_buffer_if.sv
// Pixel write / commit bus between the frame source and strip_frame_buffer.
interface strip_frame_buffer_if #(
    parameter int unsigned LENGTH = 4,
    parameter int unsigned ADDR_W = 2
);
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [7:0]               wr_red;
    logic [7:0]               wr_green;
    logic [7:0]               wr_blue;
    logic [7:0]               brightness;
    logic                     commit;
    logic                     encoder_busy;
    logic [LENGTH*24-1:0]     strip;
    logic                     frame_pending;
    logic                     commit_ack;
    logic                     wr_error;

    modport master (
        output wr_en, wr_addr, wr_red, wr_green, wr_blue, brightness,
               commit, encoder_busy,
        input  strip, frame_pending, commit_ack, wr_error
    );

    modport slave (
        input  wr_en, wr_addr, wr_red, wr_green, wr_blue, brightness,
               commit, encoder_busy,
        output strip, frame_pending, commit_ack, wr_error
    );
endinterface

// File: rtl/strip_frame_buffer.sv
// Double-buffered LED strip frame store: scaled GRB shadow writes,
// published to the encoder-facing strip only while the encoder is idle.
module strip_frame_buffer #(
    parameter int unsigned LENGTH = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    strip_frame_buffer_if.slave bus
);
    localparam int unsigned PIX_W   = 24;
    localparam int unsigned STRIP_W = LENGTH * PIX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOAD    = 2'd2
    } state_t;

    state_t               state;
    logic [PIX_W-1:0]     shadow [LENGTH];
    logic [STRIP_W-1:0]   strip_q;
    logic                 frame_pending_q;
    logic                 commit_ack_q;
    logic                 wr_error_q;
    logic                 in_range_c;
    logic [PIX_W-1:0]     pix_c;

    // Scale one colour channel by (brightness + 1) / 256.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(c) * (16'(b) + 16'd1);
        return prod[15:8];
    endfunction

    // Address check and GRB packing of the incoming pixel.
    always_comb begin
        in_range_c = (32'(bus.wr_addr) < LENGTH);
        pix_c      = {scale(bus.wr_green, bus.brightness),
                      scale(bus.wr_red,   bus.brightness),
                      scale(bus.wr_blue,  bus.brightness)};
    end

    // Shadow writes, commit FSM and publication of the strip.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            strip_q         <= '0;
            frame_pending_q <= 1'b0;
            commit_ack_q    <= 1'b0;
            wr_error_q      <= 1'b0;
            for (int i = 0; i < LENGTH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            commit_ack_q <= 1'b0;
            wr_error_q   <= bus.wr_en && !in_range_c;

            // Writes are accepted in every state; a LOAD-edge write misses this frame.
            for (int i = 0; i < LENGTH; i++) begin
                if (bus.wr_en && in_range_c && (bus.wr_addr == ADDR_W'(i))) begin
                    shadow[i] <= pix_c;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.commit) begin
                        state           <= PENDING;
                        frame_pending_q <= 1'b1;
                    end
                end
                PENDING: begin
                    if (!bus.encoder_busy) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < LENGTH; i++) begin
                        strip_q[i*PIX_W +: PIX_W] <= shadow[i];
                    end
                    commit_ack_q <= 1'b1;
                    if (bus.commit) begin
                        state           <= PENDING;
                        frame_pending_q <= 1'b1;
                    end else begin
                        state           <= IDLE;
                        frame_pending_q <= 1'b0;
                    end
                end
                default: begin
                    state           <= IDLE;
                    frame_pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.strip         = strip_q;
    assign bus.frame_pending = frame_pending_q;
    assign bus.commit_ack    = commit_ack_q;
    assign bus.wr_error      = wr_error_q;
endmodule

// File: tb/tb_strip_frame_buffer.sv
// Scoreboard bench for strip_frame_buffer (LENGTH=4, ADDR_W=3 build).
module tb_strip_frame_buffer;
    localparam int unsigned LENGTH = 4;
    localparam int unsigned ADDR_W = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;

    strip_frame_buffer_if #(.LENGTH(LENGTH), .ADDR_W(ADDR_W)) bus ();

    strip_frame_buffer #(.LENGTH(LENGTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: what the frame buffer should hold, in plain terms.
    logic [23:0] m_shadow [LENGTH];
    logic [95:0] m_strip   = '0;
    bit          m_pending = 0;   // a commit is waiting for the encoder
    bit          m_publish = 0;   // encoder seen idle; publish on next edge
    bit          m_ack     = 0;
    bit          m_err     = 0;
    logic [95:0] exp_q [$];

    function automatic logic [7:0] mscale(input int c, input int b);
        return 8'((c * (b + 1)) / 256);
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each rising edge, using the inputs held since the last negedge.
    always @(posedge clk) begin
        m_ack = 0;
        m_err = 0;
        if (reset) begin
            for (int i = 0; i < LENGTH; i++) m_shadow[i] = '0;
            m_strip   = '0;
            m_pending = 0;
            m_publish = 0;
            exp_q.delete();
        end else begin
            if (m_publish) begin
                for (int i = 0; i < LENGTH; i++) m_strip[i*24 +: 24] = m_shadow[i];
                exp_q.push_back(m_strip);
                m_ack     = 1;
                m_publish = 0;
                m_pending = bus.commit;
            end else if (m_pending) begin
                if (!bus.encoder_busy) begin
                    m_pending = 0;
                    m_publish = 1;
                end
            end else if (bus.commit) begin
                m_pending = 1;
            end
            if (bus.wr_en) begin
                if (int'(bus.wr_addr) < LENGTH)
                    m_shadow[int'(bus.wr_addr)] = {mscale(int'(bus.wr_green), int'(bus.brightness)),
                                                   mscale(int'(bus.wr_red),   int'(bus.brightness)),
                                                   mscale(int'(bus.wr_blue),  int'(bus.brightness))};
                else
                    m_err = 1;
            end
        end
    end

    // Monitor: compare outputs just after each edge; pop scoreboard on commit_ack.
    always @(posedge clk) begin
        #1;
        chk("frame_pending", 96'(bus.frame_pending), 96'(m_pending || m_publish));
        chk("commit_ack",    96'(bus.commit_ack),    96'(m_ack));
        chk("wr_error",      96'(bus.wr_error),      96'(m_err));
        chk("strip",         bus.strip,              m_strip);
        if (bus.commit_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 96'(1), 96'(0));
            end else begin
                chk("published_frame", bus.strip, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic we, input logic [2:0] a, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b, input logic [7:0] br,
                         input logic cm);
        @(negedge clk);
        bus.wr_en      = we;
        bus.wr_addr    = a;
        bus.wr_red     = r;
        bus.wr_green   = g;
        bus.wr_blue    = b;
        bus.brightness = br;
        bus.commit     = cm;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    endtask

    // Count edges until commit_ack is seen; strobes drop after the first edge.
    task automatic wait_ack(input string nm, input int exp_lat);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk);
            #2;
            lat++;
            if (lat == 1) begin
                bus.commit = 1'b0;
                bus.wr_en  = 1'b0;
            end
            if (bus.commit_ack) seen = 1;
        end
        if (!seen) lat = 999;
        chk(nm, 96'(lat), 96'(exp_lat));
    endtask

    initial begin
        bus.encoder_busy = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_red = '0; bus.wr_green = '0;
        bus.wr_blue = '0; bus.brightness = '0; bus.commit = 1'b0;

        // Reset state
        idle(3);
        @(negedge clk) reset = 1'b0;
        chk("reset_strip", bus.strip, 96'h0);
        chk("reset_pending", 96'(bus.frame_pending), 96'(0));

        // Full brightness red on pixel 0, latency of 3 edges
        drive(1'b1, 3'd0, 8'hFF, 8'h00, 8'h00, 8'd255, 1'b0);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd0, 1'b1);
        wait_ack("ack_latency", 3);
        chk("pix0_red", 96'(bus.strip[23:0]), 96'(24'h00FF00));
        chk("upper_dark", 96'(bus.strip[95:24]), 96'h0);

        // Half and zero brightness
        drive(1'b1, 3'd3, 8'hFF, 8'hFF, 8'hFF, 8'd127, 1'b0);
        drive(1'b1, 3'd2, 8'hAB, 8'hCD, 8'hEF, 8'd0, 1'b1);
        wait_ack("ack_latency_wr_commit", 3);
        chk("pix3_half", 96'(bus.strip[95:72]), 96'(24'h7F7F7F));
        chk("pix2_zero", 96'(bus.strip[71:48]), 96'(24'h000000));

        // Encoder busy for 100 cycles holds the commit
        @(negedge clk) bus.encoder_busy = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd0, 1'b1);
        idle(100);
        chk("busy_hold_pending", 96'(bus.frame_pending), 96'(1));
        chk("busy_hold_strip", bus.strip, 96'h7F7F7F_000000_000000_00FF00);
        @(negedge clk) bus.encoder_busy = 1'b0;
        wait_ack("busy_release_latency", 2);
        @(posedge clk); #1;
        chk("pending_cleared", 96'(bus.frame_pending), 96'(0));

        // Out-of-range write
        drive(1'b1, 3'd4, 8'h11, 8'h22, 8'h33, 8'd255, 1'b0);
        @(posedge clk); #1;
        chk("wr_error_pulse", 96'(bus.wr_error), 96'(1));
        idle(1);
        @(posedge clk); #1;
        chk("wr_error_clear", 96'(bus.wr_error), 96'(0));
        drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd0, 1'b1);
        wait_ack("ack_after_bad_write", 3);
        chk("strip_after_bad_write", bus.strip, 96'h7F7F7F_000000_000000_00FF00);

        // Full frame; rewrite of pixel 1 during LOAD goes to the next frame
        drive(1'b1, 3'd0, 8'hFF, 8'h00, 8'h00, 8'd255, 1'b0);
        drive(1'b1, 3'd1, 8'h00, 8'hFF, 8'hFF, 8'd255, 1'b0);
        drive(1'b1, 3'd2, 8'hC3, 8'hBD, 8'h45, 8'd255, 1'b0);
        drive(1'b1, 3'd3, 8'h43, 8'h1B, 8'h22, 8'd255, 1'b0);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd0, 1'b1);
        idle(1);
        drive(1'b1, 3'd1, 8'h34, 8'h12, 8'h56, 8'd255, 1'b0);
        idle(3);
        chk("frame_full", bus.strip, 96'h1B4322_BDC345_FF00FF_00FF00);
        drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd0, 1'b1);
        wait_ack("ack_second_commit", 3);
        chk("pix1_updated", 96'(bus.strip[47:24]), 96'(24'h123456));

        // Reset while PENDING discards the commit
        @(negedge clk) bus.encoder_busy = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'd0, 1'b1);
        idle(2);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) begin reset = 1'b0; bus.encoder_busy = 1'b0; end
        chk("reset_pend_strip", bus.strip, 96'h0);
        chk("reset_pend_fp", 96'(bus.frame_pending), 96'(0));
        idle(4);
        drive(1'b1, 3'd0, 8'h10, 8'h20, 8'h30, 8'd255, 1'b1);
        wait_ack("ack_after_reset", 3);
        chk("strip_after_reset", bus.strip, 96'h000000_000000_000000_201030);

        // Randomised traffic
        for (int k = 0; k < 600; k++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 5) == 0) bus.encoder_busy = ~bus.encoder_busy;
            reset = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk) begin reset = 1'b0; bus.encoder_busy = 1'b0; end
        idle(10);
        chk("scoreboard_drained", 96'(exp_q.size()), 96'(0));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
